// File: rtl/dmem_sized_wait.sv
// Byte-addressable data memory with sized loads/stores; ready pulses WAIT_CYCLES+1 cycles after capture, one access per WAIT_CYCLES+2 cycles.
// No backpressure beyond the request/ready handshake. Optional macro DMEM_MISALIGN_CHECK_EN flags misaligned accesses instead of masking.
`timescale 1ns/1ps
module dmem_sized_wait #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0,
  parameter int AW          = $clog2(DEPTH) + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic [2:0]    func3,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   data_in,
  output logic [31:0]   data_out,
  output logic          ready,
  output logic          misaligned
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [2:0]      f3_q, f3_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdat_q, wdat_d;
  logic [31:0]     dout_q, dout_d;
  logic            mis_q, mis_d;
  logic [31:0]     mem [DEPTH];

  logic            req;
  logic            commit;
  logic            acc_wr;
  logic [2:0]      acc_f3;
  logic [AW-1:0]   acc_addr;
  logic [31:0]     acc_wdat;
  logic            is_byte, is_half, is_word;
  logic            acc_mis;
  logic [AW-1:0]   eff_addr;
  logic [AW-3:0]   word_idx;
  logic [1:0]      lane;
  logic [31:0]     rword, rshift, ld_val;
  logic [3:0]      be;
  logic [31:0]     wd;

  assign req = MemRead | MemWrite;

  // With zero wait states the commit edge is the capture edge, so use the live inputs.
  always_comb begin
    acc_wr   = wr_q;
    acc_f3   = f3_q;
    acc_addr = addr_q;
    acc_wdat = wdat_q;
    if (state_q == S_IDLE) begin
      acc_wr   = MemWrite;
      acc_f3   = func3;
      acc_addr = addr;
      acc_wdat = data_in;
    end
  end

  assign is_byte = (acc_f3[1:0] == 2'b00);
  assign is_half = (acc_f3[1:0] == 2'b01);
  assign is_word = !is_byte && !is_half;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign acc_mis  = (is_half && acc_addr[0]) || (is_word && (acc_addr[1:0] != 2'b00));
  assign eff_addr = acc_addr;
`else
  assign acc_mis  = 1'b0;
  assign eff_addr = {acc_addr[AW-1:2],
                     is_word ? 1'b0 : acc_addr[1],
                     (is_word || is_half) ? 1'b0 : acc_addr[0]};
`endif

  assign word_idx = eff_addr[AW-1:2];
  assign lane     = eff_addr[1:0];
  assign rword    = mem[word_idx];
  assign rshift   = rword >> {lane, 3'b000};

  always_comb begin
    ld_val = rword;
    be     = 4'b1111;
    wd     = acc_wdat;
    if (is_byte) begin
      ld_val = acc_f3[2] ? {24'd0, rshift[7:0]} : {{24{rshift[7]}}, rshift[7:0]};
      be     = 4'b0001 << lane;
      wd     = {4{acc_wdat[7:0]}};
    end else if (is_half) begin
      ld_val = acc_f3[2] ? {16'd0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
      be     = lane[1] ? 4'b1100 : 4'b0011;
      wd     = {2{acc_wdat[15:0]}};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdat_q  <= 32'd0;
      dout_q  <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      dout_q  <= dout_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          wr_d    = MemWrite;
          f3_d    = func3;
          addr_d  = addr;
          wdat_d  = data_in;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign commit = (state_d == S_RESP) && (state_q != S_RESP) && !rst;

  always_comb begin
    dout_d = dout_q;
    mis_d  = mis_q;
    if (commit) begin
      mis_d = acc_mis;
      if (!acc_wr && !acc_mis) dout_d = ld_val;
    end
  end

  // Array has no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (commit && acc_wr && !acc_mis) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  // Outputs
  always_comb begin
    ready      = (state_q == S_RESP);
    data_out   = dout_q;
    misaligned = mis_q;
  end

endmodule

// File: tb/tb_dmem_sized_wait.sv
// Bench for dmem_sized_wait: one instance with no wait states, one with three, sharing request inputs.
`timescale 1ns/1ps
module tb_dmem_sized_wait;
  localparam int AW = 8;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MC = 1'b1;
`else
  localparam bit MC = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst3, mr, mw;
  logic [2:0] f3;
  logic [AW-1:0] a;
  logic [31:0] din;
  logic [31:0] dout0, dout3;
  logic rdy0, rdy3, mis0, mis3;

  dmem_sized_wait #(.DEPTH(64), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst0), .MemRead(mr), .MemWrite(mw), .func3(f3), .addr(a),
    .data_in(din), .data_out(dout0), .ready(rdy0), .misaligned(mis0));
  dmem_sized_wait #(.DEPTH(64), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst3), .MemRead(mr), .MemWrite(mw), .func3(f3), .addr(a),
    .data_in(din), .data_out(dout3), .ready(rdy3), .misaligned(mis3));

  typedef struct { logic [31:0] dout; logic mis; int lat; } exp_t;
  typedef struct { logic rd; logic wr; logic [2:0] f; logic [AW-1:0] ad;
                   logic [31:0] d; logic [31:0] ed; logic em; } vec_t;

  exp_t sb_q[$];
  vec_t tv[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f,
                              input logic [AW-1:0] ad, input logic [31:0] d,
                              input logic [31:0] ed, input logic em);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f = f; v.ad = ad; v.d = d; v.ed = ed; v.em = em;
    return v;
  endfunction

  // Drive one request, hold it until the selected instance answers, then score it.
  task automatic access(input int sel, input logic rd, input logic wr, input logic [2:0] f,
                        input logic [AW-1:0] ad, input logic [31:0] d,
                        input logic [31:0] ed, input logic em, input string nm);
    exp_t e, g;
    int lat;
    logic r;
    @(negedge clk);
    mr = rd; mw = wr; f3 = f; a = ad; din = d;
    e.dout = ed; e.mis = em; e.lat = (sel == 3) ? 4 : 1;
    sb_q.push_back(e);
    lat = 0;
    r = 1'b0;
    while (!r && lat < 40) begin
      @(negedge clk);
      lat++;
      r = (sel == 3) ? rdy3 : rdy0;
    end
    mr = 1'b0; mw = 1'b0;
    g = sb_q.pop_front();
    if (!r) begin
      chk({nm, "_timeout"}, 32'(lat), 32'(g.lat));
    end else begin
      chk({nm, "_lat"}, 32'(lat), 32'(g.lat));
      chk({nm, "_dout"}, (sel == 3) ? dout3 : dout0, g.dout);
      chk({nm, "_mis"}, {31'd0, (sel == 3) ? mis3 : mis0}, {31'd0, g.mis});
      @(negedge clk);
      chk({nm, "_pulse"}, {31'd0, (sel == 3) ? rdy3 : rdy0}, 32'd0);
    end
  endtask

  initial begin
    logic seen;
    int cyc, k;
    int at [3];

    mr = 1'b0; mw = 1'b0; f3 = 3'd0; a = '0; din = 32'd0;
    rst0 = 1'b1; rst3 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_dout0", dout0, 32'd0);
    chk("rst_rdy0", {31'd0, rdy0}, 32'd0);
    chk("rst_mis0", {31'd0, mis0}, 32'd0);
    chk("rst_rdy3", {31'd0, rdy3}, 32'd0);
    rst0 = 1'b0; rst3 = 1'b0;

    //          rd    wr    f3      addr    data          exp dout                        exp mis
    tv.push_back(mk(1'b0, 1'b1, 3'b010, 8'd4,  32'h8,        32'h0,                          1'b0));
    tv.push_back(mk(1'b1, 1'b0, 3'b010, 8'd4,  32'h0,        32'h00000008,                   1'b0));
    tv.push_back(mk(1'b0, 1'b1, 3'b010, 8'd0,  32'h80FF7F01, 32'h00000008,                   1'b0));
    tv.push_back(mk(1'b1, 1'b0, 3'b000, 8'd3,  32'h0,        32'hFFFFFF80,                   1'b0));
    tv.push_back(mk(1'b1, 1'b0, 3'b100, 8'd3,  32'h0,        32'h00000080,                   1'b0));
    tv.push_back(mk(1'b1, 1'b0, 3'b001, 8'd2,  32'h0,        32'hFFFF80FF,                   1'b0));
    tv.push_back(mk(1'b1, 1'b0, 3'b101, 8'd0,  32'h0,        32'h00007F01,                   1'b0));
    tv.push_back(mk(1'b0, 1'b1, 3'b000, 8'd1,  32'h123456AA, 32'h00007F01,                   1'b0));
    tv.push_back(mk(1'b1, 1'b0, 3'b010, 8'd0,  32'h0,        32'h80FFAA01,                   1'b0));
    tv.push_back(mk(1'b1, 1'b1, 3'b010, 8'd12, 32'h55,       32'h80FFAA01,                   1'b0));
    tv.push_back(mk(1'b1, 1'b0, 3'b010, 8'd12, 32'h0,        32'h00000055,                   1'b0));
    tv.push_back(mk(1'b0, 1'b1, 3'b001, 8'd1,  32'hBEEF,     32'h00000055,                   MC));
    tv.push_back(mk(1'b1, 1'b0, 3'b010, 8'd0,  32'h0,        MC ? 32'h80FFAA01 : 32'h80FFBEEF, 1'b0));
    tv.push_back(mk(1'b1, 1'b0, 3'b010, 8'd14, 32'h0,        MC ? 32'h80FFAA01 : 32'h00000055, MC));
    tv.push_back(mk(1'b1, 1'b0, 3'b101, 8'd3,  32'h0,        MC ? 32'h80FFAA01 : 32'h000080FF, MC));
    tv.push_back(mk(1'b1, 1'b0, 3'b011, 8'd4,  32'h0,        32'h00000008,                   1'b0));

    foreach (tv[i])
      access(0, tv[i].rd, tv[i].wr, tv[i].f, tv[i].ad, tv[i].d, tv[i].ed, tv[i].em,
             $sformatf("v%0d", i));

    repeat (6) @(negedge clk);
    chk("idle_hold_dout0", dout0, 32'h00000008);
    chk("idle_hold_mis0", {31'd0, mis0}, 32'd0);

    // Wait-state instance, starting from a clean reset.
    rst3 = 1'b1;
    repeat (2) @(negedge clk);
    rst3 = 1'b0;
    access(3, 1'b0, 1'b1, 3'b010, 8'd8, 32'h0000CAFE, 32'h0, 1'b0, "w3_sw");
    access(3, 1'b1, 1'b0, 3'b010, 8'd8, 32'h0,        32'h0000CAFE, 1'b0, "w3_lw");

    // Reset while the store sits in WAIT: it must vanish without a ready pulse.
    @(negedge clk);
    mw = 1'b1; mr = 1'b0; f3 = 3'b010; a = 8'd8; din = 32'h00001234;
    @(negedge clk);
    seen = rdy3;
    rst3 = 1'b1;
    @(negedge clk);
    seen = seen | rdy3;
    rst3 = 1'b0; mw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | rdy3;
    end
    chk("rst_mid_no_ready", {31'd0, seen}, 32'd0);
    access(3, 1'b1, 1'b0, 3'b010, 8'd8, 32'h0, 32'h0000CAFE, 1'b0, "rst_mid_lw");

    // Continuous MemRead: pulses every WAIT_CYCLES+2 cycles.
    at[0] = 0; at[1] = 0; at[2] = 0;
    @(negedge clk);
    mr = 1'b1; mw = 1'b0; f3 = 3'b010; a = 8'd8;
    cyc = 0; k = 0;
    while (k < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (rdy3) begin
        at[k] = cyc;
        k++;
      end
    end
    mr = 1'b0;
    chk("hold_pulse_count", 32'(k), 32'd3);
    chk("hold_first", 32'(at[0]), 32'd4);
    chk("hold_gap1", 32'(at[1] - at[0]), 32'd5);
    chk("hold_gap2", 32'(at[2] - at[1]), 32'd5);
    chk("hold_dout3", dout3, 32'h0000CAFE);
    repeat (8) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
